// File: rtl/demux_gates.sv
// demux_gates: a one-hot decoder on {a,b} feeding minterm-OR gates, followed by a STAGES-deep valid pipeline.
// Optional sticky decode checker (dec_err port) is built only when DEMUX_GATES_ONEHOT_CHK_EN is defined.
module demux_gates #(
   parameter int STAGES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       a,
   input  logic       b,
   output logic       out_valid,
   output logic [3:0] minterm,
   output logic       xor_g,
   output logic       xnor_g,
   output logic       and_g,
   output logic       or_g,
   output logic       nand_g,
   output logic       nor_g
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
   ,
   output logic       dec_err
`endif
);

   localparam int DW = 10;

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("demux_gates: STAGES must be in the range 1..4");
      end
   endgenerate

   logic [3:0]                 minterm_c;
   logic [DW-1:0]              gates_c;
   logic [STAGES-1:0]          vld_d;
   logic [STAGES-1:0]          vld_q;
   logic [STAGES-1:0][DW-1:0]  dat_d;
   logic [STAGES-1:0][DW-1:0]  dat_q;

   // One-hot decode of the operand pair; an unknown select decodes to all-zero
   always_comb begin
      minterm_c = 4'b0000;
      case ({a, b})
         2'b00:   minterm_c = 4'b0001;
         2'b01:   minterm_c = 4'b0010;
         2'b10:   minterm_c = 4'b0100;
         2'b11:   minterm_c = 4'b1000;
         default: minterm_c = 4'b0000;
      endcase
   end

   // Every gate is an OR of minterms; NAND uses m0|m1|m2 rather than inverting m3
   always_comb begin
      gates_c = {minterm_c,
                 minterm_c[1] | minterm_c[2],
                 minterm_c[0] | minterm_c[3],
                 minterm_c[3],
                 minterm_c[1] | minterm_c[2] | minterm_c[3],
                 minterm_c[0] | minterm_c[1] | minterm_c[2],
                 minterm_c[0]};
   end

   // Next-state of the pipeline: data advances only alongside a set valid bit
   always_comb begin
      vld_d    = {STAGES{1'b0}};
      dat_d    = dat_q;
      vld_d[0] = in_valid;
      if (in_valid) begin
         dat_d[0] = gates_c;
      end else begin
         dat_d[0] = dat_q[0];
      end
      for (int i = 1; i < STAGES; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
         end else begin
            dat_d[i] = dat_q[i];
         end
      end
   end

   // Pipeline registers; reset drops all in-flight results at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= {STAGES{1'b0}};
         dat_q <= {(STAGES*DW){1'b0}};
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign {minterm, xor_g, xnor_g, and_g, or_g, nand_g, nor_g} = dat_q[STAGES-1];

`ifdef DEMUX_GATES_ONEHOT_CHK_EN
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
   endfunction

   logic dec_err_d;
   logic dec_err_q;

   // Sticky flag: latches on any malformed decode or broken complement pair on a valid output
   always_comb begin
      dec_err_d = dec_err_q;
      if (out_valid && (!is_onehot4(minterm) || (xnor_g == xor_g) ||
                        (nand_g == and_g) || (nor_g == or_g))) begin
         dec_err_d = 1'b1;
      end else begin
         dec_err_d = dec_err_q;
      end
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_err_q <= 1'b0;
      end else begin
         dec_err_q <= dec_err_d;
      end
   end

   assign dec_err = dec_err_q;
`endif

endmodule

// File: tb/tb_demux_gates.sv
// Directed and table-driven bench for demux_gates, running STAGES=1, 3 and 4 instances side by side.
module tb_demux_gates;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic a;
   logic b;

   logic       o1_v, o3_v, o4_v;
   logic [3:0] o1_m, o3_m, o4_m;
   logic       o1_x, o1_xn, o1_an, o1_or, o1_na, o1_no;
   logic       o3_x, o3_xn, o3_an, o3_or, o3_na, o3_no;
   logic       o4_x, o4_xn, o4_an, o4_or, o4_na, o4_no;
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
   logic       e1, e3, e4;
`endif

   logic [9:0] d1, d3, d4;
   assign d1 = {o1_m, o1_x, o1_xn, o1_an, o1_or, o1_na, o1_no};
   assign d3 = {o3_m, o3_x, o3_xn, o3_an, o3_or, o3_na, o3_no};
   assign d4 = {o4_m, o4_x, o4_xn, o4_an, o4_or, o4_na, o4_no};

   demux_gates #(.STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(o1_v), .minterm(o1_m), .xor_g(o1_x), .xnor_g(o1_xn),
      .and_g(o1_an), .or_g(o1_or), .nand_g(o1_na), .nor_g(o1_no)
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
      , .dec_err(e1)
`endif
   );

   demux_gates #(.STAGES(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(o3_v), .minterm(o3_m), .xor_g(o3_x), .xnor_g(o3_xn),
      .and_g(o3_an), .or_g(o3_or), .nand_g(o3_na), .nor_g(o3_no)
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
      , .dec_err(e3)
`endif
   );

   demux_gates #(.STAGES(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(o4_v), .minterm(o4_m), .xor_g(o4_x), .xnor_g(o4_xn),
      .and_g(o4_an), .or_g(o4_or), .nand_g(o4_na), .nor_g(o4_no)
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
      , .dec_err(e4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       in_valid;
      logic       a;
      logic       b;
      logic       exp_valid;
      logic [9:0] exp_dat;
   } vec_t;

   // Reference gate values using plain boolean operators; bit order {minterm,xor,xnor,and,or,nand,nor}
   function automatic logic [9:0] model(input logic ma, input logic mb);
      logic [3:0] m;
      m = 4'b0001 << {ma, mb};
      return {m, ma ^ mb, ~(ma ^ mb), ma & mb, ma | mb, ~(ma & mb), ~(ma | mb)};
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_inv(input string name, input logic [9:0] d);
      logic ok;
      ok = (d[4] === ~d[5]) && (d[1] === ~d[3]) && (d[0] === ~d[2]) &&
           ((d[9:6] === 4'b0001) || (d[9:6] === 4'b0010) ||
            (d[9:6] === 4'b0100) || (d[9:6] === 4'b1000));
      check(name, {10'd0, ok}, 11'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t       tbl [7];
   logic [9:0] exp_d;
   logic       exp_v;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'b0001_010011};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'b0010_100110};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'b0100_100110};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'b1000_011100};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'b1000_011100};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'b1000_011100};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'b0010_100110};

      // Reset with random operands: everything cleared
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 1'($urandom_range(1));
      b        = 1'($urandom_range(1));
      step();
      a = 1'($urandom_range(1));
      b = 1'($urandom_range(1));
      step();
      check("rst_s1", {o1_v, d1}, 11'd0);
      check("rst_s3", {o3_v, d3}, 11'd0);
      check("rst_s4", {o4_v, d4}, 11'd0);
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
      check("rst_err", {8'd0, e1, e3, e4}, 11'd0);
`endif
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      check("post_rst_s1", {o1_v, d1}, 11'd0);
      check("post_rst_s4", {o4_v, d4}, 11'd0);

      // Single pulse a=1,b=0 through the 3-stage instance
      in_valid = 1'b1; a = 1'b1; b = 1'b0;
      step();
      in_valid = 1'b0; a = 1'b0; b = 1'b0;
      check("s3_lat1", {o3_v, d3}, 11'd0);
      step();
      check("s3_lat2", {o3_v, d3}, 11'd0);
      step();
      check("s3_lat3", {o3_v, d3}, {1'b1, 10'b0100_100110});
      step();
      check("s3_lat4", {o3_v, d3}, {1'b0, 10'b0100_100110});

      // Table of vectors against the 1-stage instance
      for (int i = 0; i < 7; i++) begin
         in_valid = tbl[i].in_valid;
         a        = tbl[i].a;
         b        = tbl[i].b;
         step();
         check($sformatf("tbl%0d", i), {o1_v, d1}, {tbl[i].exp_valid, tbl[i].exp_dat});
      end

      // Result 11 then five idle cycles with changing operands: output holds
      in_valid = 1'b1; a = 1'b1; b = 1'b1;
      step();
      check("hold_load", {o1_v, d1}, {1'b1, 10'b1000_011100});
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b0;
         a        = 1'(i);
         b        = 1'(i >> 1);
         step();
         check($sformatf("hold%0d", i), {o1_v, d1}, {1'b0, 10'b1000_011100});
      end

      // Three results in flight in the 4-stage instance, then a one-cycle reset
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = 1'(i >> 1);
         b        = 1'(i);
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("s4_rst_now", {o4_v, d4}, 11'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("s4_flush%0d", i), {o4_v, d4}, 11'd0);
      end

      // Random traffic: scoreboard on 1-stage, invariants on every valid output
      exp_v = 1'b0;
      exp_d = 10'd0;
      for (int i = 0; i < 1000; i++) begin
         in_valid = ($urandom_range(9) < 8) ? 1'b1 : 1'b0;
         a        = 1'($urandom_range(1));
         b        = 1'($urandom_range(1));
         exp_v    = in_valid;
         if (in_valid) exp_d = model(a, b);
         step();
         check("rnd_s1", {o1_v, d1}, {exp_v, exp_d});
         if (o1_v) check_inv("inv_s1", d1);
         if (o3_v) check_inv("inv_s3", d3);
         if (o4_v) check_inv("inv_s4", d4);
      end
`ifdef DEMUX_GATES_ONEHOT_CHK_EN
      check("rnd_err", {8'd0, e1, e3, e4}, 11'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
